// File: rtl/cursor_measure.sv
// Cursor-pair measurement for the seven-segment display: |X2-X1| or |Y2-Y1| scaled by a
// sequential shift-add multiply, saturated to 0..9999. Optional 4-sample mean: MEAS_AVG4_EN.
module cursor_measure #(
  parameter int          REFRESH_DIV = 2500000,
  parameter logic [7:0]  SCALE_X     = 8'd4,
  parameter logic [7:0]  SCALE_Y     = 8'd1,
  parameter int          FRAC_BITS   = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cursorX_EN,
  input  logic        cursorY_EN,
  input  logic [10:0] cursorX1,
  input  logic [10:0] cursorX2,
  input  logic [10:0] cursorY1,
  input  logic [10:0] cursorY2,
  output logic [13:0] number,
  output logic [3:0]  seg_En,
  output logic        saturated,
  output logic        valid,
  output logic        busy
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  typedef enum logic [2:0] {IDLE, CAPT, MULT, SAT, OUT} state_t;
  typedef enum logic [1:0] {MODE_NONE, MODE_X, MODE_Y} mode_t;

  function automatic logic [10:0] abs_diff(input logic [10:0] a, input logic [10:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Returns {clipped, value}.
  function automatic logic [14:0] saturate(input logic [18:0] v);
    if (v > 19'd9999)
      return {1'b1, 14'd9999};
    else
      return {1'b0, v[13:0]};
  endfunction

  function automatic logic [3:0] seg_rule(input logic none, input logic [13:0] v);
    if (none)              return 4'b0000;
    else if (v >= 14'd1000) return 4'b1111;
    else if (v >= 14'd100)  return 4'b0111;
    else if (v >= 14'd10)   return 4'b0011;
    else                    return 4'b0001;
  endfunction

  logic [CNT_W-1:0] cnt;
  logic             tick;
  state_t           state_q, state_d;
  logic [3:0]       bit_cnt;

  mode_t            mode_p0;
  logic [10:0]      delta_p0;
  logic [18:0]      scale_p0;
  logic [18:0]      product_p1;

  logic [18:0]      shifted_p2;
  logic [14:0]      sat_word_p2;
  logic [13:0]      r_val_p2;
  logic             r_sat_p2;
  logic [13:0]      out_val_p2;
  logic             out_sat_p2;

  // Free-running refresh divider; ticks arriving while busy are simply ignored by the FSM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (cnt == CNT_MAX)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == CNT_MAX);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bit_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == MULT)
        bit_cnt <= bit_cnt + 1'b1;
      else
        bit_cnt <= '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick) state_d = CAPT;
      CAPT:    state_d = MULT;
      MULT:    if (bit_cnt == 4'd10) state_d = SAT;
      SAT:     state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  // Stage p0/p1: capture operands, then shift-add one delta bit per MULT cycle.
  always_ff @(posedge clock) begin
    if (state_q == CAPT) begin
      product_p1 <= '0;
      if (cursorX_EN) begin
        mode_p0  <= MODE_X;
        delta_p0 <= abs_diff(cursorX1, cursorX2);
        scale_p0 <= {11'd0, SCALE_X};
      end else if (cursorY_EN) begin
        mode_p0  <= MODE_Y;
        delta_p0 <= abs_diff(cursorY1, cursorY2);
        scale_p0 <= {11'd0, SCALE_Y};
      end else begin
        mode_p0  <= MODE_NONE;
        delta_p0 <= '0;
        scale_p0 <= '0;
      end
    end else if (state_q == MULT) begin
      if (delta_p0[0])
        product_p1 <= product_p1 + scale_p0;
      delta_p0 <= delta_p0 >> 1;
      scale_p0 <= scale_p0 << 1;
    end
  end

  // Stage p2: fixed-point shift and clip, evaluated during SAT.
  always_comb begin
    shifted_p2  = product_p1 >> FRAC_BITS;
    sat_word_p2 = saturate(shifted_p2);
    r_val_p2    = sat_word_p2[13:0];
    r_sat_p2    = sat_word_p2[14];
    if (mode_p0 == MODE_NONE) begin
      r_val_p2 = '0;
      r_sat_p2 = 1'b0;
    end
  end

`ifdef MEAS_AVG4_EN
  logic [3:0][13:0] hist;
  logic [3:0]       hist_sat;
  logic             hist_vld;
  mode_t            hist_mode;
  logic             reload_p2;
  logic [15:0]      avg_sum_p2;

  // A fresh start or a mode change refills the history so the mean tracks the new value at once.
  always_comb begin
    reload_p2 = !hist_vld || (hist_mode != mode_p0);
    if (reload_p2) begin
      avg_sum_p2 = {r_val_p2, 2'b00};
      out_sat_p2 = r_sat_p2;
    end else begin
      avg_sum_p2 = {2'b00, r_val_p2} + {2'b00, hist[0]} + {2'b00, hist[1]} + {2'b00, hist[2]};
      out_sat_p2 = r_sat_p2 | hist_sat[0] | hist_sat[1] | hist_sat[2];
    end
    out_val_p2 = avg_sum_p2[15:2];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hist_vld  <= 1'b0;
      hist_mode <= MODE_NONE;
      hist_sat  <= '0;
    end else if (state_q == SAT) begin
      hist_vld  <= 1'b1;
      hist_mode <= mode_p0;
      if (reload_p2)
        hist_sat <= {4{r_sat_p2}};
      else
        hist_sat <= {hist_sat[2:0], r_sat_p2};
    end
  end

  always_ff @(posedge clock) begin
    if (state_q == SAT) begin
      if (reload_p2)
        hist <= {4{r_val_p2}};
      else
        hist <= {hist[2:0], r_val_p2};
    end
  end
`else
  always_comb begin
    out_val_p2 = r_val_p2;
    out_sat_p2 = r_sat_p2;
  end
`endif

  // Output stage: registered on the SAT->OUT edge together with the valid pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      number    <= '0;
      seg_En    <= 4'b0000;
      saturated <= 1'b0;
      valid     <= 1'b0;
    end else begin
      valid <= (state_q == SAT);
      if (state_q == SAT) begin
        number    <= out_val_p2;
        saturated <= out_sat_p2;
        seg_En    <= seg_rule(mode_p0 == MODE_NONE, out_val_p2);
      end
    end
  end

endmodule

// File: tb/tb_cursor_measure.sv
// Directed bench for cursor_measure: REFRESH_DIV=16, SCALE_X=8, SCALE_Y=1, FRAC_BITS=0.
module tb_cursor_measure;

  logic        clock = 1'b0;
  logic        reset;
  logic        cursorX_EN, cursorY_EN;
  logic [10:0] cursorX1, cursorX2, cursorY1, cursorY2;
  logic [13:0] number;
  logic [3:0]  seg_En;
  logic        saturated, valid, busy;

  int checks = 0;
  int errors = 0;
  int ecnt;

  // Mean-of-4 reference history, used when the averaging build is selected.
  int hv = 0;
  int hmode = 0;
  int h[4];
  int hs[4];

  cursor_measure #(
    .REFRESH_DIV(16),
    .SCALE_X(8'd8),
    .SCALE_Y(8'd1),
    .FRAC_BITS(0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cursorX_EN(cursorX_EN),
    .cursorY_EN(cursorY_EN),
    .cursorX1(cursorX1),
    .cursorX2(cursorX2),
    .cursorY1(cursorY1),
    .cursorY2(cursorY2),
    .number(number),
    .seg_En(seg_En),
    .saturated(saturated),
    .valid(valid),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Edges since reset release; the DUT tick falls where ecnt%16 == 15.
  always @(posedge clock or posedge reset) begin
    if (reset) ecnt <= 0;
    else       ecnt <= ecnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] seg_model(input int mode, input int v);
    if (mode == 0)      return 4'b0000;
    else if (v >= 1000) return 4'b1111;
    else if (v >= 100)  return 4'b0111;
    else if (v >= 10)   return 4'b0011;
    else                return 4'b0001;
  endfunction

  // mode: 0 none, 1 X, 2 Y. exp_* are the raw single-shot results.
  task automatic measure(input string tag, input logic xe, input logic ye,
                         input int x1, input int x2, input int y1, input int y2,
                         input int exp_n, input logic [3:0] exp_seg, input logic exp_sat,
                         input int mode);
    int n, s, mean_n, mean_s;
    logic [3:0] seg_e;
    bit found;
    cursorX_EN = xe;
    cursorY_EN = ye;
    cursorX1 = x1[10:0];
    cursorX2 = x2[10:0];
    cursorY1 = y1[10:0];
    cursorY2 = y2[10:0];
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      if (valid) found = 1;
    end
    chk({tag, "_valid_seen"}, found, 1);
    if (found) begin
      if (hv == 0 || hmode != mode) begin
        for (int k = 0; k < 4; k++) begin
          h[k] = exp_n;
          hs[k] = exp_sat;
        end
      end else begin
        for (int k = 3; k > 0; k--) begin
          h[k] = h[k-1];
          hs[k] = hs[k-1];
        end
        h[0] = exp_n;
        hs[0] = exp_sat;
      end
      hv = 1;
      hmode = mode;
      mean_n = (h[0] + h[1] + h[2] + h[3]) / 4;
      mean_s = hs[0] | hs[1] | hs[2] | hs[3];
`ifdef MEAS_AVG4_EN
      n = mean_n;
      s = mean_s;
      seg_e = seg_model(mode, mean_n);
`else
      n = exp_n;
      s = exp_sat;
      seg_e = exp_seg;
      if (seg_model(mode, mean_n) === 4'bxxxx || mean_s < 0) n = -1;
`endif
      chk({tag, "_latency"}, ecnt % 16, 13);
      chk({tag, "_number"}, number, n);
      chk({tag, "_seg_En"}, seg_En, seg_e);
      chk({tag, "_saturated"}, saturated, s);
      chk({tag, "_busy_out"}, busy, 1);
      @(negedge clock);
      chk({tag, "_valid_pulse"}, valid, 0);
      chk({tag, "_busy_idle"}, busy, 0);
      chk({tag, "_hold"}, number, n);
    end
  endtask

  initial begin
    cursorX_EN = 1'b1;
    cursorY_EN = 1'b0;
    cursorX1 = 11'd100;
    cursorX2 = 11'd150;
    cursorY1 = 11'd0;
    cursorY2 = 11'd0;

    // Reset held for 3 cycles.
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("rst_number", number, 0);
      chk("rst_seg", seg_En, 4'b0000);
      chk("rst_valid", valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sat", saturated, 0);
    end
    reset = 1'b0;

    measure("x_100_150", 1, 0, 100, 150, 0, 0, 400, 4'b0111, 0, 1);
    measure("x_swap",    1, 0, 150, 100, 0, 0, 400, 4'b0111, 0, 1);
    measure("x_full",    1, 0, 0, 2047, 0, 0, 9999, 4'b1111, 1, 1);
    measure("x_9992",    1, 0, 1249, 0, 0, 0, 9992, 4'b1111, 0, 1);
    measure("x_10000",   1, 0, 0, 1250, 0, 0, 9999, 4'b1111, 1, 1);
    measure("xy_prio",   1, 1, 10, 11, 0, 500, 8, 4'b0001, 0, 1);
    measure("y_equal",   0, 1, 0, 0, 7, 7, 0, 4'b0001, 0, 2);
    measure("y_25",      0, 1, 0, 0, 30, 5, 25, 4'b0011, 0, 2);

    // Reset in the middle of the multiply.
    for (int i = 0; i < 20 && (ecnt % 16) != 6; i++) @(negedge clock);
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_number", number, 0);
    chk("mid_rst_seg", seg_En, 4'b0000);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clock);
    @(negedge clock);
    chk("mid_rst_valid2", valid, 0);
    reset = 1'b0;
    hv = 0;

    measure("after_rst", 1, 0, 100, 150, 0, 0, 400, 4'b0111, 0, 1);
    measure("none",      0, 0, 5, 900, 3, 60, 0, 4'b0000, 0, 0);
    measure("y_100",     0, 1, 0, 0, 0, 100, 100, 4'b0111, 0, 2);
    measure("y_200a",    0, 1, 0, 0, 0, 200, 200, 4'b0111, 0, 2);
    measure("y_200b",    0, 1, 0, 0, 200, 0, 200, 4'b0111, 0, 2);
    measure("y_200c",    0, 1, 0, 0, 0, 200, 200, 4'b0111, 0, 2);
    measure("x_switch",  1, 0, 0, 50, 0, 0, 400, 4'b0111, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
